// File: rtl/ff_rsra_shift.sv
// Serial-in / parallel-out shift register with asynchronous active-low reset.
// Shift direction is chosen at elaboration time; S_OUT is the next bit to leave.
`timescale 1ns/1ps
module ff_rsra_shift #(
  parameter int                WIDTH       = 4,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int                SHIFT_LEFT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Per-bit next-state wiring: each bit takes its upstream neighbour, the entry bit takes D.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (SHIFT_LEFT != 0) begin : g_left
        if (gi == 0) begin : g_entry
          assign w_next[gi] = D;
        end else begin : g_chain
          assign w_next[gi] = r_q[gi-1];
        end
      end else begin : g_right
        if (gi == WIDTH-1) begin : g_entry
          assign w_next[gi] = D;
        end else begin : g_chain
          assign w_next[gi] = r_q[gi+1];
        end
      end
    end
  endgenerate

  // A clock edge that still sees rst low keeps the reset value, so a release
  // coincident with an edge only starts shifting on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_next;
    end
  end

  assign Q     = r_q;
  assign S_OUT = (SHIFT_LEFT != 0) ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: tb/tb_ff_rsra_shift.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
// Two instances share clk/rst: 4-bit left shifter and 8-bit right shifter.
`timescale 1ns/1ps
module tb_ff_rsra_shift;

  logic       clk;
  logic       rst;
  logic       d4;
  logic       d8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       s4;
  logic       s8;

  ff_rsra_shift #(.WIDTH(4), .RESET_VALUE(4'b0000), .SHIFT_LEFT(1)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .D     (d4),
    .Q     (q4),
    .S_OUT (s4)
  );

  ff_rsra_shift #(.WIDTH(8), .RESET_VALUE(8'h00), .SHIFT_LEFT(0)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .D     (d8),
    .Q     (q8),
    .S_OUT (s8)
  );

  typedef struct {
    string      name;
    bit         sel8;
    logic [7:0] exp_q;
    logic       exp_s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input bit sel8, input logic [7:0] q, input logic s);
    exp_t it;
    it.name  = name;
    it.sel8  = sel8;
    it.exp_q = q;
    it.exp_s = s;
    sb.push_back(it);
  endtask

  // Monitor: compares the selected DUT outputs whenever an expectation is pending.
  initial begin
    exp_t       it;
    logic [7:0] act_q;
    logic       act_s;
    forever begin
      wait (sb.size() != 0);
      it    = sb.pop_front();
      act_q = it.sel8 ? q8 : {4'b0000, q4};
      act_s = it.sel8 ? s8 : s4;
      n_checks++;
      if (act_q !== it.exp_q || act_s !== it.exp_s) begin
        n_errors++;
        $display("FAIL %s: got Q=%h S_OUT=%b, expected Q=%h S_OUT=%b",
                 it.name, act_q, act_s, it.exp_q, it.exp_s);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] pa_d;
  logic [3:0] pa_q [4];
  logic [3:0] pc_q4 [9];
  logic [7:0] pc_q8 [9];

  initial begin
    pa_d  = 4'b0101;  // applied LSB first: 1,0,1,0
    pa_q  = '{4'h1, 4'h2, 4'h5, 4'hA};
    pc_q4 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    pc_q8 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

    rst = 1'b1;
    d4  = 1'b0;
    d8  = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_async4", 0, 8'h00, 1'b0);
    chk("rst_async8", 1, 8'h00, 1'b0);
    d4 = 1'b1;
    d8 = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_edge4", 0, 8'h00, 1'b0);
    chk("rst_hold_edge8", 1, 8'h00, 1'b0);

    // Release at a falling edge, then shift 1,0,1,0.
    @(negedge clk);
    rst = 1'b1;
    d8  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d4 = pa_d[i];
      @(posedge clk); #1;
      chk($sformatf("shift_a%0d", i), 0, {4'b0000, pa_q[i]}, pa_q[i][3]);
      @(negedge clk);
    end

    // Mid-operation reset: immediate clear, then held while D toggles.
    rst = 1'b0;
    #1;
    chk("mid_rst_async", 0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d4 = ~d4;
      d8 = ~d8;
      @(posedge clk); #1;
      chk($sformatf("rst_hold4_%0d", i), 0, 8'h00, 1'b0);
      chk($sformatf("rst_hold8_%0d", i), 1, 8'h00, 1'b0);
    end

    // Fill with ones (4-bit) and single-pulse walk (8-bit, right shift).
    @(negedge clk);
    rst = 1'b1;
    d4  = 1'b1;
    d8  = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      chk($sformatf("fill4_e%0d", e + 1), 0, {4'b0000, pc_q4[e]}, (e >= 3));
      chk($sformatf("walk8_e%0d", e + 1), 1, pc_q8[e], (e == 7));
      @(negedge clk);
      d8 = 1'b0;
    end

    // Release coincident with a rising edge: the flop still sees rst low on that edge.
    rst = 1'b0;
    d4  = 1'b1;
    @(posedge clk);
    rst <= 1'b1;
    #1;
    chk("rel_coincident", 0, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("rel_next_edge", 0, 8'h01, 1'b0);
    chk("rel_next_edge8", 1, 8'h00, 1'b0);

    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ff_rsra_shift.md
FF_RSRA_SHIFT -- requirements
Module: ff_rsra_shift

Interface
REQ-001: Parameter WIDTH, default 4: register length in bits; the block SHALL support any WIDTH >= 2.
REQ-002: Parameter RESET_VALUE, default all-zeros (WIDTH bits): value loaded into Q while reset is asserted.
REQ-003: Parameter SHIFT_LEFT, default 1: 1 = D enters Q[0] and data moves toward Q[WIDTH-1]; 0 = D enters Q[WIDTH-1] and data moves toward Q[0].
REQ-004: Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge only.
REQ-005: Port rst, input, 1 bit: reset, asynchronous, active-low (0 = reset asserted).
REQ-006: Port D, input, 1 bit: serial data in.
REQ-007: Port Q, output, WIDTH bits: parallel register contents, driven directly from flip-flops.
REQ-008: Port S_OUT, output, 1 bit: serial out; the bit shifted out next (Q[WIDTH-1] when SHIFT_LEFT=1, else Q[0]); may be left unconnected.

Function
REQ-009: The block SHALL be a WIDTH-bit serial-in/parallel-out shift register built from D flip-flops sharing clk and rst.
REQ-010: With SHIFT_LEFT=1, on each rising clk edge with rst=1, Q SHALL become {Q[WIDTH-2:0], D}.
REQ-011: With SHIFT_LEFT=0, on each rising clk edge with rst=1, Q SHALL become {D, Q[WIDTH-1:1]}.
REQ-012: Latency: a bit applied on D SHALL appear in Q[0] (SHIFT_LEFT=1) one rising edge later and at S_OUT WIDTH edges later.
REQ-013: The block SHALL shift on every rising edge; there is no enable, no hold state, and no parallel load.
REQ-014: Q SHALL change only on a rising clk edge or on reset assertion; D changes between edges SHALL have no effect.
REQ-015: D SHALL be ignored while rst=0; X on D during reset SHALL NOT propagate into Q.
REQ-016: S_OUT SHALL be purely combinational from Q, with no additional register stage.

Reset
REQ-017: Asserting rst=0 SHALL force Q to RESET_VALUE immediately, without waiting for a clk edge.
REQ-018: While rst=0, Q SHALL hold RESET_VALUE regardless of clk and D.
REQ-019: On a rising clk edge coincident with rst releasing (0->1), the register SHALL remain at RESET_VALUE; shifting starts on the first rising edge that sees rst=1.
REQ-020: Reset asserted mid-operation SHALL discard all shifted data, with Q reaching RESET_VALUE within the same time step.
REQ-021: After power-up Q is undefined until the first reset assertion; no initial value is required.

Verification
REQ-022: clk period 10 ns, rst=0 for one cycle -> Q=4'b0000 before the first rising edge.
REQ-023: Release rst; apply D=1,0,1,0 on successive falling edges -> Q after each rising edge = 0001, 0010, 0101, 1010.
REQ-024: From Q=4'b1010, drive rst=0 at a falling edge -> Q=4'b0000 at once, with no clk edge needed, and it stays 0000 while D toggles.
REQ-025: Hold D=1 for 4 edges after reset -> Q = 0001, 0011, 0111, 1111; S_OUT rises on the 4th edge.
REQ-026: Release rst coincident with a rising edge while D=1 -> Q stays 0000 on that edge and becomes 0001 on the next.
REQ-027: SHIFT_LEFT=0, WIDTH=8, D=1 for one cycle then 0 -> Q=8'h80 after edge 1, 8'h01 after edge 8, 8'h00 after edge 9; S_OUT=1 only between edges 8 and 9.
